// File: rtl/y86_seq_sequencer.sv
// Six-stage multi-cycle sequencer for the Y86 core: owns PC, processor status and
// the retired-instruction count, and strobes each datapath stage in turn.
module y86_seq_sequencer #(
  parameter int unsigned         DATA_WID  = 32,
  parameter logic [DATA_WID-1:0] RESET_PC  = {DATA_WID{1'b0}},
  parameter int unsigned         COUNT_W   = 32,
  parameter int unsigned         TIMEOUT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  input  logic [3:0]          icode,
  input  logic                instr_valid,
  input  logic                imem_error,
  input  logic                mem_ack,
  input  logic                dmem_error,
  input  logic [DATA_WID-1:0] next_pc,
  output logic [DATA_WID-1:0] pc,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                pcupd_en,
  output logic                cc_we,
  output logic                mem_req,
  output logic [1:0]          stat,
  output logic                halted,
  output logic [COUNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_OPQ  = 4'h6;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}};

  // rmmovq, mrmovq, call, ret, pushq and popq touch data memory
  function automatic logic needs_mem(input logic [3:0] ic);
    logic hit;
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_e               state_q, state_d;
  logic [DATA_WID-1:0]  pc_q, pc_d;
  logic [1:0]           stat_q, stat_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [5:0]           stage_en_q, stage_en_d;
  logic                 mem_req_q, mem_req_d;
  logic                 cc_we_q, cc_we_d;
  logic                 halted_q, halted_d;

  // Stage transitions plus the architectural updates made on leaving each stage
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == IC_HALT) begin
          stat_d    = STAT_HLT;
          retired_d = retired_q + COUNT_W'(1);
          state_d   = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        tmo_d   = {TIMEOUT_W{1'b0}};
        state_d = S_MEM;
      end
      S_MEM: begin
        // An acknowledge in the final wait cycle takes precedence over the timeout
        if (!mem_req_q) begin
          state_d = S_WB;
        end else if (mem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          tmo_d   = tmo_q + TIMEOUT_W'(1);
          state_d = S_MEM;
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d      = next_pc;
        retired_d = retired_q + COUNT_W'(1);
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered, so the flops track the state exactly
  always_comb begin
    stage_en_d = 6'b000000;
    case (state_d)
      S_FETCH:  stage_en_d = 6'b100000;
      S_DECODE: stage_en_d = 6'b010000;
      S_EXEC:   stage_en_d = 6'b001000;
      S_MEM:    stage_en_d = 6'b000100;
      S_WB:     stage_en_d = 6'b000010;
      S_PCUPD:  stage_en_d = 6'b000001;
      default:  stage_en_d = 6'b000000;
    endcase
    mem_req_d = (state_d == S_MEM) && needs_mem(icode);
    cc_we_d   = (state_d == S_EXEC) && (icode == IC_OPQ);
    halted_d  = (state_d == S_HALT);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      stat_q     <= STAT_AOK;
      retired_q  <= {COUNT_W{1'b0}};
      tmo_q      <= {TIMEOUT_W{1'b0}};
      stage_en_q <= 6'b000000;
      mem_req_q  <= 1'b0;
      cc_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stat_q     <= stat_d;
      retired_q  <= retired_d;
      tmo_q      <= tmo_d;
      stage_en_q <= stage_en_d;
      mem_req_q  <= mem_req_d;
      cc_we_q    <= cc_we_d;
      halted_q   <= halted_d;
    end
  end

  assign {fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en} = stage_en_q;
  assign pc      = pc_q;
  assign stat    = stat_q;
  assign retired = retired_q;
  assign mem_req = mem_req_q;
  assign cc_we   = cc_we_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Randomized bench: expected per-cycle traces come from a stage-list model of each instruction.
module tb_y86_seq_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;

  logic        CLK = 1'b0;
  logic        RST, run, instr_valid, imem_error, mem_ack, dmem_error;
  logic [3:0]  icode;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en;
  logic        cc_we, mem_req, halted;
  logic [1:0]  stat;
  logic [3:0]  retired;

  y86_seq_sequencer #(
    .DATA_WID(32), .RESET_PC(RPC), .COUNT_W(4), .TIMEOUT_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .run(run), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .next_pc(next_pc), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .pcupd_en(pcupd_en),
    .cc_we(cc_we), .mem_req(mem_req), .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef logic [46:0] samp_t;
  samp_t       exp_q[$];
  samp_t       obs_q[$];
  logic [31:0] mdl_pc;
  logic [3:0]  mdl_ret;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic bit is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic [3:0] pick_mem_op();
    case ($urandom_range(5, 0))
      0: return 4'h4;
      1: return 4'h5;
      2: return 4'h8;
      3: return 4'h9;
      4: return 4'hA;
      default: return 4'hB;
    endcase
  endfunction

  // st: 0..5 = FETCH..PCUPD, -1 = no stage active
  function automatic samp_t mk(input int st, input bit req, input bit cc, input bit hlt, input logic [1:0] s);
    logic [5:0] str;
    str = (st >= 0) ? (6'b100000 >> st) : 6'b000000;
    return {str, req, cc, hlt, s, mdl_pc, mdl_ret};
  endfunction

  function automatic samp_t sample_dut();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en, mem_req, cc_we, halted, stat, pc, retired};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; run = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0; next_pc = 32'h0;
    #2;
    RST = 1'b0;
    mdl_pc = RPC;
    mdl_ret = 4'd0;
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
  endtask

  // Expected trace: F, then either a halt sample, or D, E, MEM x (1+wait), W, P
  task automatic build_exp(input logic [3:0] ic, input bit valid, input bit ierr,
                           input int ack_d, input bit derr, input logic [31:0] npc);
    bit done;
    int nmem;
    done = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, AOK));
    if (ierr) begin
      exp_q.push_back(mk(-1, 0, 0, 1, ADR));
      done = 1'b1;
    end else if (!valid) begin
      exp_q.push_back(mk(-1, 0, 0, 1, INS));
      done = 1'b1;
    end else if (ic == 4'h0) begin
      mdl_ret = mdl_ret + 4'd1;
      exp_q.push_back(mk(-1, 0, 0, 1, HLT));
      done = 1'b1;
    end else begin
      exp_q.push_back(mk(1, 0, 0, 0, AOK));
      exp_q.push_back(mk(2, 0, ic == 4'h6, 0, AOK));
      if (!is_mem(ic)) begin
        exp_q.push_back(mk(3, 0, 0, 0, AOK));
      end else if (ack_d >= 0 && ack_d <= 15) begin
        nmem = ack_d + 1;
        repeat (nmem) exp_q.push_back(mk(3, 1, 0, 0, AOK));
        if (derr) begin
          exp_q.push_back(mk(-1, 0, 0, 1, ADR));
          done = 1'b1;
        end
      end else begin
        repeat (16) exp_q.push_back(mk(3, 1, 0, 0, AOK));
        exp_q.push_back(mk(-1, 0, 0, 1, ADR));
        done = 1'b1;
      end
    end
    if (!done) begin
      exp_q.push_back(mk(4, 0, 0, 0, AOK));
      exp_q.push_back(mk(5, 0, 0, 0, AOK));
      mdl_pc = npc;
      mdl_ret = mdl_ret + 4'd1;
    end
  endtask

  // Drives one instruction from FETCH, recording samples until PCUPD or HALT (bounded)
  task automatic drive_instr(input logic [3:0] ic, input bit valid, input bit ierr, input int ack_d,
                             input bit derr, input logic [31:0] npc, input bit drop_run);
    int mem_cnt = 0;
    icode = ic; instr_valid = valid; imem_error = ierr; next_pc = npc;
    obs_q.delete();
    for (int c = 0; c < 40; c++) begin
      obs_q.push_back(sample_dut());
      if (halted || pcupd_en) break;
      if (mem_en && is_mem(ic)) begin
        mem_cnt++;
        mem_ack = (ack_d >= 0) && (mem_cnt == ack_d + 1);
        dmem_error = mem_ack ? derr : 1'($urandom_range(1, 0));
      end else begin
        mem_ack = 1'($urandom_range(1, 0));
        dmem_error = 1'($urandom_range(1, 0));
      end
      if (drop_run && decode_en) run = 1'b0;
      step();
    end
    mem_ack = 1'b0;
    dmem_error = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; run = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0; next_pc = 32'h0;
    mdl_pc = RPC; mdl_ret = 4'd0;
    #1;
    n_vec++;
    if (sample_dut() !== mk(-1, 0, 0, 0, AOK)) begin
      n_err++; $display("FAIL reset_hold: got %h expected %h", sample_dut(), mk(-1, 0, 0, 0, AOK));
    end
    #1;
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if (sample_dut() !== mk(-1, 0, 0, 0, AOK)) begin
        n_err++; $display("FAIL idle_stay[%0d]: got %h expected %h", k, sample_dut(), mk(-1, 0, 0, 0, AOK));
      end
    end
  endtask

  task automatic test_nops();
    logic [31:0] npc;
    do_reset();
    start_run();
    for (int k = 0; k < 3; k++) begin
      npc = mdl_pc + 32'd1;
      build_exp(4'h1, 1'b1, 1'b0, -1, 1'b0, npc);
      drive_instr(4'h1, 1'b1, 1'b0, -1, 1'b0, npc, 1'b0);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL nop_len[%0d]: got %0d cycles expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL nop[%0d.%0d]: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      step();
    end
    n_vec++;
    if (sample_dut() !== mk(0, 0, 0, 0, AOK)) begin
      n_err++; $display("FAIL nops_after: got %h expected %h", sample_dut(), mk(0, 0, 0, 0, AOK));
    end
  endtask

  task automatic test_mem_wait();
    int          acks [6] = '{3, 0, 15, 7, 11, 2};
    logic [3:0]  ic;
    logic [31:0] npc;
    bit          derr;
    for (int k = 0; k < 6; k++) begin
      ic   = (k == 0) ? 4'h5 : pick_mem_op();
      npc  = $urandom;
      derr = (k == 5);
      build_exp(ic, 1'b1, 1'b0, acks[k], derr, npc);
      drive_instr(ic, 1'b1, 1'b0, acks[k], derr, npc, 1'b0);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL mem_len[%0d]: got %0d cycles expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL mem[%0d.%0d]: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_timeout();
    samp_t hs;
    do_reset();
    start_run();
    build_exp(4'h4, 1'b1, 1'b0, -1, 1'b0, 32'h1234);
    drive_instr(4'h4, 1'b1, 1'b0, -1, 1'b0, 32'h1234, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL tmo_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL tmo[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    hs = mk(-1, 0, 0, 1, ADR);
    for (int k = 0; k < 3; k++) begin
      run = 1'b1; icode = 4'($urandom_range(11, 1)); mem_ack = 1'($urandom_range(1, 0));
      step();
      n_vec++;
      if (sample_dut() !== hs) begin
        n_err++; $display("FAIL halt_hold[%0d]: got %h expected %h", k, sample_dut(), hs);
      end
    end
  endtask

  task automatic test_fetch_faults();
    logic [3:0] ics   [3] = '{4'h2, 4'h3, 4'h0};
    bit         vals  [3] = '{1'b0, 1'b0, 1'b1};
    bit         ierrs [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      start_run();
      build_exp(ics[k], vals[k], ierrs[k], -1, 1'b0, 32'h0);
      drive_instr(ics[k], vals[k], ierrs[k], -1, 1'b0, 32'h0, 1'b0);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL fetch_len[%0d]: got %0d cycles expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL fetch[%0d.%0d]: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_cc_pause();
    logic [31:0] npc;
    do_reset();
    start_run();
    for (int k = 0; k < 2; k++) begin
      npc = $urandom;
      build_exp((k == 0) ? 4'h6 : 4'h2, 1'b1, 1'b0, -1, 1'b0, npc);
      drive_instr((k == 0) ? 4'h6 : 4'h2, 1'b1, 1'b0, -1, 1'b0, npc, k == 0);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL cc_len[%0d]: got %0d cycles expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL cc[%0d.%0d]: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      step();
      if (k == 0) begin
        for (int j = 0; j < 3; j++) begin
          n_vec++;
          if (sample_dut() !== mk(-1, 0, 0, 0, AOK)) begin
            n_err++; $display("FAIL pause_idle[%0d]: got %h expected %h", j, sample_dut(), mk(-1, 0, 0, 0, AOK));
          end
          if (j < 2) step();
        end
        start_run();
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] npc;
    do_reset();
    start_run();
    npc = $urandom | 32'h1000;
    build_exp(4'h1, 1'b1, 1'b0, -1, 1'b0, npc);
    drive_instr(4'h1, 1'b1, 1'b0, -1, 1'b0, npc, 1'b0);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL pre_rst[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    step();
    icode = 4'h5;
    repeat (3) step();
    n_vec++;
    if (sample_dut() !== mk(3, 1, 0, 0, AOK)) begin
      n_err++; $display("FAIL in_mem: got %h expected %h", sample_dut(), mk(3, 1, 0, 0, AOK));
    end
    #2;
    RST = 1'b1;
    mdl_pc = RPC; mdl_ret = 4'd0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || pc !== RPC) begin
      n_err++; $display("FAIL async_rst: got mem_req=%b pc=%h expected mem_req=0 pc=%h", mem_req, pc, RPC);
    end
    n_vec++;
    if (sample_dut() !== mk(-1, 0, 0, 0, AOK)) begin
      n_err++; $display("FAIL async_rst_all: got %h expected %h", sample_dut(), mk(-1, 0, 0, 0, AOK));
    end
    RST = 1'b0;
    run = 1'b0;
    step();
  endtask

  task automatic test_random_wrap();
    logic [3:0]  ic;
    logic [31:0] npc;
    int          ack_d;
    do_reset();
    start_run();
    for (int k = 0; k < 28; k++) begin
      ic    = (k < 16) ? 4'h1 : 4'($urandom_range(11, 1));
      npc   = $urandom;
      ack_d = $urandom_range(15, 0);
      build_exp(ic, 1'b1, 1'b0, ack_d, 1'b0, npc);
      drive_instr(ic, 1'b1, 1'b0, ack_d, 1'b0, npc, 1'b0);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand_len[%0d]: got %0d cycles expected %0d", k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand[%0d.%0d]: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      step();
      if (k == 15) begin
        n_vec++;
        if (retired !== 4'd0) begin
          n_err++; $display("FAIL wrap: got retired=%0d expected 0", retired);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_mem_wait();
    test_timeout();
    test_fetch_faults();
    test_cc_pause();
    test_async_reset();
    test_random_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
